instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
// Requester side of the synchronous instruction BROM port (clka/ena/addra/douta).
// - Holds the PC and issues one word read per cycle to instruction memory.
// - Presents each fetched instruction, with its PC, on a valid/ready interface to decode.
// - Handles the 1-cycle BROM read latency, decode backpressure and branch/jump redirects.
// PARAMETERS
// ADDR_W    32  PC / imem address width
// DATA_W    32  instruction width
// RESET_PC  0   first fetch address after reset
// PC_STEP   1   PC increment per instruction (word-addressed BROM)
// PORTS
// clka            in   1       clock (shared with BROM)
// rst_n           in   1       async active-low reset
// imem_en         out  1       BROM ena; low = BROM holds douta
// imem_addr       out  ADDR_W  BROM addra
// imem_dout       in   DATA_W  BROM douta; valid 1 cycle after an en=1 edge
// redirect_valid  in   1       taken branch/jump this cycle
// redirect_pc     in   ADDR_W  redirect target
// instr_valid     out  1       instr/instr_pc hold a valid fetch
// instr_ready     in   1       decode accepts on valid&ready edge
// instr           out  DATA_W  fetched instruction (registered)
// instr_pc        out  ADDR_W  PC of instr (registered)
// BEHAVIOUR
// - Reset (async, any time): pc_q=RESET_PC, rd_pend=0, rd_pc=0, instr_valid=0, instr=0,
//   instr_pc=0. imem_en=0 while rst_n=0. Reset mid-stream discards all in-flight state.
// - adv = !instr_valid | instr_ready. Combinational outputs when out of reset:
//   imem_en = redirect_valid | adv
//   imem_addr = redirect_valid ? redirect_pc : pc_q
// - Edge with redirect_valid=1 (wins over stall/backpressure):
//   pc_q <= redirect_pc+PC_STEP; rd_pend<=1; rd_pc<=redirect_pc; instr_valid<=0.
//   The in-flight read and the output register are flushed.
// - Edge with adv=1, no redirect:
//   {instr_valid,instr,instr_pc} <= {rd_pend,imem_dout,rd_pc};
//   rd_pend<=1; rd_pc<=pc_q; pc_q<=pc_q+PC_STEP.
// - Edge with adv=0, no redirect: all registers hold. en=0 keeps BROM douta stable,
//   so the pending word is neither lost nor re-read.
// - Latency: address issue -> instr_valid is 2 edges. After reset or redirect, the first
//   valid is at the 2nd edge. Sustained throughput is 1 instr/cycle when ready=1.
// - Ordering: each PC is delivered exactly once, in order, until the next redirect.
// - PC arithmetic is modulo 2^ADDR_W: 0xFFFFFFFF + 1 wraps to 0, no flag raised.
// - Internal state flag run: 0 in reset, 1 from the first edge after deassert.
//   No other FSM states.
// CONFIGURATION
// IFU_PERF_CNT_EN defined:
//   adds outputs fetch_cnt[31:0] (+1 per valid&ready edge) and
//   bubble_cnt[31:0] (+1 per edge with ready=1 & instr_valid=0, after reset).
//   Both reset to 0 and wrap silently.
// IFU_PERF_CNT_EN undefined: ports and counters are absent; behaviour is otherwise identical.
// TESTING
// 1 Reset release, BROM mem[i]=0x1000+i, ready=1 -> addr 0,1,2..;
//   first valid at edge 2 with instr=0x1000, instr_pc=0, then one per cycle.
// 2 Streaming, ready=0 for 3 cycles while valid -> imem_en=0 for those cycles, instr held;
//   on resume, next instr_pc = held+1 (no drop, no duplicate).
// 3 Redirect to 0x40 while streaming -> instr_valid=0 for 1 cycle;
//   next valid instr_pc=0x40, instr=mem[0x40]; stale in-flight PC never appears.
// 4 Redirect to 0x80 with ready=0 and valid=1 the same cycle -> held instr dropped;
//   imem_addr=0x80, en=1; next valid pc=0x80.
// 5 RESET_PC=0xFFFFFFFE -> delivered PCs FFFFFFFE, FFFFFFFF, 0, 1.
// 6 rst_n pulled low mid-stream between edges -> instr_valid=0 and imem_en=0 immediately;
//   after release, restarts at RESET_PC. With IFU_PERF_CNT_EN: 10 accepts + 2 bubbles
//   -> fetch_cnt=10, bubble_cnt=2.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch requester for a 1-cycle-latency instruction BROM; IFU_PERF_CNT_EN adds fetch/bubble counters
module instr_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 1
) (
  input  logic              clka,
  input  logic              rst_n,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_dout,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] rd_pc;
  logic              rd_pend;
  logic              run;
  logic              adv;

  // The output slot can take a new word when it is empty or being consumed.
  assign adv = !instr_valid | instr_ready;

  // BROM request: a redirect always reads its target; otherwise read only when the
  // output slot can move, so a stalled douta stays put for the pending word.
  always_comb begin
    imem_en   = rst_n & (redirect_valid | adv);
    imem_addr = redirect_valid ? redirect_pc : pc_q;
  end

  // PC, in-flight read tracking and the registered output slot.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      rd_pend     <= 1'b0;
      rd_pc       <= '0;
      run         <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else begin
      run <= 1'b1;
      if (redirect_valid) begin
        // Flush both the in-flight read and the presented word; target read starts now.
        pc_q        <= redirect_pc + STEP;
        rd_pend     <= 1'b1;
        rd_pc       <= redirect_pc;
        instr_valid <= 1'b0;
      end else if (adv) begin
        // On the first edge out of reset nothing was read yet, hence the run qualifier.
        instr_valid <= rd_pend & run;
        instr       <= imem_dout;
        instr_pc    <= rd_pc;
        rd_pend     <= 1'b1;
        rd_pc       <= pc_q;
        pc_q        <= pc_q + STEP;
      end
    end
  end

`ifdef IFU_PERF_CNT_EN
  // Accepted instructions and cycles where decode was ready but starved.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (instr_valid & instr_ready)  fetch_cnt  <= fetch_cnt + 32'd1;
      if (instr_ready & !instr_valid) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit with BROM models
module tb_instr_fetch_unit;

  logic        clka;
  logic        rst_n, rst2_n;
  logic        imem_en, imem_en2;
  logic [31:0] imem_addr, imem_addr2;
  logic [31:0] imem_dout, imem_dout2;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_valid2;
  logic        instr_ready;
  logic [31:0] instr, instr2;
  logic [31:0] instr_pc, instr_pc2;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt, bubble_cnt, fetch_cnt2, bubble_cnt2;
`endif

  int checks = 0;
  int errors = 0;
  int n_accept = 0;

  logic [31:0] exp_q[$];
  logic [31:0] seg_next;
  logic [31:0] got2_pc[$];
  logic [31:0] got2_instr[$];

  instr_fetch_unit dut (
    .clka(clka), .rst_n(rst_n), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_dout(imem_dout), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
`ifdef IFU_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFE)) dut2 (
    .clka(clka), .rst_n(rst2_n), .imem_en(imem_en2), .imem_addr(imem_addr2),
    .imem_dout(imem_dout2), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .instr_valid(instr_valid2), .instr_ready(1'b1), .instr(instr2), .instr_pc(instr_pc2)
`ifdef IFU_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt2), .bubble_cnt(bubble_cnt2)
`endif
  );

  function automatic logic [31:0] brom(input logic [31:0] a);
    return 32'h1000 + a;
  endfunction

  always #5 clka = ~clka;

  // Synchronous BROMs: douta updates only on an enabled edge.
  always @(posedge clka) if (imem_en)  imem_dout  <= brom(imem_addr);
  always @(posedge clka) if (imem_en2) imem_dout2 <= brom(imem_addr2);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected stream: consecutive PCs from the latest start point, kept a few entries ahead.
  function automatic void refill();
    while (exp_q.size() < 4) begin
      exp_q.push_back(seg_next);
      seg_next = seg_next + 32'd1;
    end
  endfunction

  function automatic void start_seg(input logic [31:0] t);
    exp_q.delete();
    seg_next = t;
    refill();
  endfunction

  // Monitor: every handshake must deliver the next expected PC and its BROM word.
  always @(negedge clka) begin
    if (rst_n && instr_valid && instr_ready) begin
      logic [31:0] e;
      n_accept++;
      if (exp_q.size() == 0) begin
        chk("stream_empty", instr_pc, 32'hxxxx_xxxx);
      end else begin
        e = exp_q.pop_front();
        chk("stream_pc", instr_pc, e);
        chk("stream_instr", instr, brom(e));
        refill();
      end
    end
  end

  // Collector for the wrap-around instance.
  always @(negedge clka) begin
    if (rst2_n && instr_valid2 && got2_pc.size() < 4) begin
      got2_pc.push_back(instr_pc2);
      got2_instr.push_back(instr2);
    end
  end

  task automatic step();
    @(posedge clka); #1;
  endtask

  initial begin
    logic [31:0] held;
    logic        redir;
    int          acc0;
    clka = 0; rst_n = 0; rst2_n = 0;
    redirect_valid = 0; redirect_pc = 0; instr_ready = 0;
    step(); step();
    chk("rst_valid", instr_valid, 0);
    chk("rst_en", imem_en, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", instr_pc, 0);

    // 1: reset release, streaming
    start_seg(32'h0);
    instr_ready = 1; rst_n = 1; rst2_n = 1;
    #1;
    chk("t1_en0", imem_en, 1);
    chk("t1_addr0", imem_addr, 32'h0);
    step();
    chk("t1_valid_e1", instr_valid, 0);
    chk("t1_addr1", imem_addr, 32'h1);
    step();
    chk("t1_valid_e2", instr_valid, 1);
    chk("t1_pc_e2", instr_pc, 32'h0);
    chk("t1_instr_e2", instr, 32'h1000);
    repeat (3) step();

    // 2: backpressure for 3 cycles
    held = instr_pc;
    for (int i = 0; i < 3; i++) begin
      instr_ready = 0;
      #1;
      chk("t2_en_stall", imem_en, 0);
      chk("t2_held_pc", instr_pc, held);
      chk("t2_held_valid", instr_valid, 1);
      step();
    end
    instr_ready = 1;
    repeat (3) step();

    // 3: redirect while streaming
    redirect_valid = 1; redirect_pc = 32'h40;
    #1;
    chk("t3_addr", imem_addr, 32'h40);
    chk("t3_en", imem_en, 1);
    step();
    redirect_valid = 0;
    start_seg(32'h40);
    chk("t3_bubble", instr_valid, 0);
    step();
    chk("t3_valid", instr_valid, 1);
    chk("t3_pc", instr_pc, 32'h40);
    chk("t3_instr", instr, brom(32'h40));
    repeat (2) step();

    // 4: redirect while stalled with a valid word held
    instr_ready = 0; redirect_valid = 1; redirect_pc = 32'h80;
    #1;
    chk("t4_valid_before", instr_valid, 1);
    chk("t4_addr", imem_addr, 32'h80);
    chk("t4_en", imem_en, 1);
    step();
    redirect_valid = 0; instr_ready = 1;
    start_seg(32'h80);
    chk("t4_dropped", instr_valid, 0);
    step();
    chk("t4_pc", instr_pc, 32'h80);

    // Randomized traffic with random redirects
    acc0 = n_accept;
    for (int i = 0; i < 600; i++) begin
      instr_ready    = ($urandom_range(0, 3) != 0);
      redir          = ($urandom_range(0, 15) == 0);
      redirect_valid = redir;
      redirect_pc    = $urandom;
      step();
      if (redir) start_seg(redirect_pc);
      redirect_valid = 0;
    end
    checks++;
    if (n_accept - acc0 < 150) begin
      errors++;
      $display("FAIL random_progress: got %0d accepts expected at least 150", n_accept - acc0);
    end
    instr_ready = 1;
    repeat (3) step();

    // 6: asynchronous reset between edges, then restart
    #2;
    rst_n = 0;
    #1;
    chk("t6_valid_async", instr_valid, 0);
    chk("t6_en_async", imem_en, 0);
    step();
    start_seg(32'h0);
    instr_ready = 1; rst_n = 1;
    repeat (12) step();
    chk("t6_restart_pc", instr_pc, 32'd10);
`ifdef IFU_PERF_CNT_EN
    chk("t6_fetch_cnt", fetch_cnt, 32'd10);
    chk("t6_bubble_cnt", bubble_cnt, 32'd2);
`endif

    // 5: PC wrap on the second instance
    chk("t5_count", got2_pc.size(), 4);
    for (int k = 0; k < 4 && k < got2_pc.size(); k++) begin
      chk("t5_pc", got2_pc[k], 32'hFFFF_FFFE + k);
      chk("t5_instr", got2_instr[k], brom(32'hFFFF_FFFE + k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
